// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller behind the UART receiver. It hunts for a sync byte and
// parses a length-prefixed, checksummed packet into a local payload buffer.
// An inter-byte timeout is counted in s_tick periods. Accepted payloads are
// replayed downstream over a valid/ready stream. Bad frames are discarded
// and reported through frame_err and err_code.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT_TICKS = 320
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] out_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          DEPTH     = 1 << AW;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DELIVER
  } state_t;

  state_t state, state_nxt;

  logic [7:0]  payload_buf [0:DEPTH-1];
  logic        buf_we;

  logic [7:0]  len_reg, len_nxt;
  logic [7:0]  sum, sum_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  rd_idx, rd_idx_nxt;
  logic [7:0]  rd_idx_inc;
  logic [15:0] to_cnt, to_cnt_nxt;

  logic        out_valid_nxt;
  logic [7:0]  out_data_nxt;
  logic        out_last_nxt;
  logic [7:0]  out_len_nxt;
  logic        frame_ok_nxt;
  logic        frame_err_nxt;
  logic [1:0]  err_code_nxt;
  logic        busy_nxt;
  logic [7:0]  drop_nxt;

  logic        in_frame;
  logic        timeout_hit;

  // A timeout only fires on a tick with no byte; a coinciding byte wins.
  assign in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign timeout_hit = in_frame && s_tick && !rx_done_tick && (to_cnt == TO_LAST);
  assign rd_idx_inc  = rd_idx + 8'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from received bytes, timeout and downstream handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_done_tick && (rx_dout == SYNC_BYTE)) state_nxt = LEN;
      end
      LEN: begin
        if (rx_done_tick) begin
          if (rx_dout > MAX_LEN_B)   state_nxt = IDLE;
          else if (rx_dout == 8'd0)  state_nxt = CSUM;
          else                       state_nxt = PAYLOAD;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      PAYLOAD: begin
        if (rx_done_tick) begin
          if (idx == len_reg - 8'd1) state_nxt = CSUM;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      CSUM: begin
        if (rx_done_tick) begin
          if ((rx_dout == sum) && (len_reg != 8'd0)) state_nxt = DELIVER;
          else                                       state_nxt = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      DELIVER: begin
        if (out_valid && out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the datapath and every registered output.
  always_comb begin
    len_nxt       = len_reg;
    sum_nxt       = sum;
    idx_nxt       = idx;
    rd_idx_nxt    = rd_idx;
    to_cnt_nxt    = 16'd0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    out_len_nxt   = out_len;
    frame_ok_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    err_code_nxt  = err_code;
    drop_nxt      = drop_cnt;
    buf_we        = 1'b0;
    busy_nxt      = (state_nxt != IDLE);

    if (in_frame && (state_nxt != IDLE)) begin
      if (rx_done_tick) to_cnt_nxt = 16'd0;
      else if (s_tick)  to_cnt_nxt = to_cnt + 16'd1;
      else              to_cnt_nxt = to_cnt;
    end

    case (state)
      LEN: begin
        if (rx_done_tick) begin
          len_nxt = rx_dout;
          sum_nxt = rx_dout;
          idx_nxt = 8'd0;
          if (rx_dout > MAX_LEN_B) begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'd1;
          end
        end
      end
      PAYLOAD: begin
        if (rx_done_tick) begin
          buf_we  = 1'b1;
          sum_nxt = sum + rx_dout;
          idx_nxt = idx + 8'd1;
        end
      end
      CSUM: begin
        if (rx_done_tick) begin
          if (rx_dout == sum) begin
            frame_ok_nxt = 1'b1;
            out_len_nxt  = len_reg;
            if (len_reg != 8'd0) begin
              out_valid_nxt = 1'b1;
              out_data_nxt  = payload_buf[0];
              out_last_nxt  = (len_reg == 8'd1);
              rd_idx_nxt    = 8'd0;
            end
          end else begin
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'd3;
          end
        end
      end
      DELIVER: begin
        if (rx_done_tick && (drop_cnt != 8'hFF)) drop_nxt = drop_cnt + 8'd1;
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
          end else begin
            rd_idx_nxt   = rd_idx_inc;
            out_data_nxt = payload_buf[rd_idx_inc[AW-1:0]];
            out_last_nxt = (rd_idx_inc == len_reg - 8'd1);
          end
        end
      end
      default: ;
    endcase

    if (timeout_hit) begin
      frame_err_nxt = 1'b1;
      err_code_nxt  = 2'd2;
    end
  end

  // Payload storage; contents are irrelevant after reset so it is not cleared.
  always_ff @(posedge clk) begin
    if (buf_we) payload_buf[idx[AW-1:0]] <= rx_dout;
  end

  // Register datapath state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg   <= 8'd0;
      sum       <= 8'd0;
      idx       <= 8'd0;
      rd_idx    <= 8'd0;
      to_cnt    <= 16'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
      out_len   <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      len_reg   <= len_nxt;
      sum       <= sum_nxt;
      idx       <= idx_nxt;
      rd_idx    <= rd_idx_nxt;
      to_cnt    <= to_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      out_len   <= out_len_nxt;
      frame_ok  <= frame_ok_nxt;
      frame_err <= frame_err_nxt;
      err_code  <= err_code_nxt;
      busy      <= busy_nxt;
      drop_cnt  <= drop_nxt;
    end
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame-level controller sitting directly behind the UART receiver: consumes its byte stream (`rx_done_tick` and `dout`) and the shared oversampling `s_tick`, and hunts for a sync byte. It parses a length-prefixed, checksummed packet into a local payload buffer, enforces an inter-byte timeout counted in `s_tick` periods, and replays accepted payloads to the downstream game/command logic over a valid/ready stream. Corrupt, oversized or stalled frames are discarded and reported.

## Interface
- Reset is synchronous and active-high. The block uses a single clock, `clk`, and the reset port is named `reset`.
- `MAX_LEN`, 16: payload buffer depth in bytes, valid range 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_TICKS`, 320: `s_tick` periods allowed between consecutive bytes of one frame (2 character times at 16x oversampling); 16-bit counter.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `s_tick` in 1: baud oversampling tick, same source as the receiver.
- `rx_done_tick` in 1: one-cycle byte-received pulse from the receiver.
- `rx_dout` in 8: received byte; valid in the `rx_done_tick` cycle.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_valid` out 1: payload byte available.
- `out_data` out 8: payload byte.
- `out_last` out 1: qualifies final payload byte.
- `out_len` out 8: length of the frame being delivered, held until the next accepted frame.
- `frame_ok` out 1: one-cycle pulse, frame checksum matched.
- `frame_err` out 1: one-cycle pulse, frame discarded.
- `err_code` out 2: 1 = length > MAX_LEN, 2 = timeout, 3 = checksum mismatch; held until next error.
- `busy` out 1: high in every state except IDLE.
- `drop_cnt` out 8: saturating count of bytes dropped during DELIVER.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DELIVER.
- A byte is "accepted" on any clock edge where `rx_done_tick`=1.
- IDLE: an accepted byte equal to SYNC_BYTE -> LEN. Any other byte is ignored. No timeout counting.
- LEN: accepted byte L goes to `len_reg` and `sum` = L, and `idx` is cleared.
  - If L > MAX_LEN: `frame_err`, `err_code`=1 -> IDLE.
  - If L = 0 -> CSUM.
  - Otherwise -> PAYLOAD.
- PAYLOAD: the accepted byte is written to `buf[idx]`, `sum` += byte (mod 256) and `idx`++. When `idx` reaches `len_reg`-1 on a write -> CSUM.
- CSUM: on an accepted byte C:
  - If C == `sum`: `frame_ok` pulses and `out_len` = `len_reg`. Then -> DELIVER if `len_reg` > 0, else -> IDLE.
  - Else: `frame_err`, `err_code`=3 -> IDLE.
- DELIVER:
  - `out_valid`=1, `out_data`=`buf[rd_idx]` and `out_last`=(`rd_idx`==`len_reg`-1).
  - A transfer occurs when `out_valid`&`out_ready`. Each transfer does `rd_idx`++. The transfer with `out_last` -> IDLE.
  - Bytes accepted in DELIVER are discarded and increment `drop_cnt`, which saturates at 255. They are never treated as SYNC.
- Timeout, in LEN/PAYLOAD/CSUM only:
  - `to_cnt` clears on entry to LEN and on every accepted byte, and increments on `s_tick`.
  - When `to_cnt` reaches TIMEOUT_TICKS-1 and `s_tick`=1 with no byte accepted: `frame_err`, `err_code`=2 -> IDLE.
- The checksum is the 8-bit wrap-around sum of the LEN byte and all payload bytes. The sync byte is excluded.

## Timing
- All outputs are registered. Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_len`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, `busy`=0, `drop_cnt`=0; state=IDLE, `to_cnt`=0.
- `frame_ok` and `frame_err` are asserted in the cycle after the deciding byte's `rx_done_tick`. `out_valid` rises in that same cycle.
- Outputs in DELIVER are stable while `out_valid`=1 and `out_ready`=0. A new byte is presented the cycle after each transfer. Sustained `out_ready`=1 gives one byte per clock.
- `busy` drops the cycle after the last transfer or error.
- When `rx_done_tick` and the final timeout `s_tick` coincide, the byte wins: it is processed and `to_cnt` clears.
- Reset mid-frame or mid-delivery aborts immediately. No `frame_err` is generated and the buffer contents are don't-care.

## Test plan
- Good frame: A5,03,11,22,33,69 with `out_ready`=1 -> `frame_ok` pulse, then 11,22,33 on consecutive cycles, `out_last` on 33, `out_len`=3, `busy` low after.
- Backpressure: same frame with `out_ready` toggling 0/1 -> 11,22,33 each held stable until a transfer occurs. Two bytes sent during DELIVER -> `drop_cnt`=2.
- Bad checksum: A5,02,01,02,00 -> `frame_err`, `err_code`=3, no `out_valid`. Then A5,00,00 -> `frame_ok`, no delivery.
- Oversize: A5,11 (17 > MAX_LEN=16) -> `err_code`=1. The next valid frame is received normally.
- Timeout: A5,04,AA then 320 `s_tick`s of silence -> `err_code`=2, `busy`=0. A separate case where a byte lands on exactly the 320th tick -> no error.
- Noise/reset: 00,FF,A5,01,7E,7F -> one byte 7E delivered. Assert `reset` during PAYLOAD -> all outputs return to reset values next cycle.
